m3_motorcmdsequencer: RTL

Front-end controller for the 3-phase drive's power/speed calculator. It debounces seven raw operator keys and sequences them into the calculator's control inputs: start, force-stop, invert-rotation, speed and power step requests. A direction change runs a safe sequence of brake, stop, dwell, invert and restart. It sits between the board key inputs and the power/speed calculation block, with all outputs registered.

---
 rtl/m3_ctrl_pkg.sv | 35 +++
 rtl/m3_keyDebounce.sv | 49 ++++
 rtl/m3_motorcmdsequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/m3_ctrl_pkg.sv
// Shared constants for the motor command sequencer: FSM state codes, key indices and
// default timing parameters.
package m3_ctrl_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StBrake = 3'd2;
  localparam logic [2:0] StHalt  = 3'd3;
  localparam logic [2:0] StDwell = 3'd4;
  localparam logic [2:0] StFstop = 3'd5;

  localparam int unsigned NumKeys = 7;
  localparam int unsigned KeyStart = 0;
  localparam int unsigned KeyStop  = 1;
  localparam int unsigned KeyDir   = 2;
  localparam int unsigned KeySpdUp = 3;
  localparam int unsigned KeySpdDn = 4;
  localparam int unsigned KeyPwrUp = 5;
  localparam int unsigned KeyPwrDn = 6;

`ifdef simulating
  localparam int unsigned DefDebCycles   = 4;
  localparam int unsigned DefBrakeCycles = 20;
  localparam int unsigned DefDwellCycles = 8;
`else
  localparam int unsigned DefDebCycles   = 20000;
  localparam int unsigned DefBrakeCycles = 2000000;
  localparam int unsigned DefDwellCycles = 500000;
`endif

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/m3_keyDebounce.sv
// Two-flop synchronizer plus stable-sample debouncer for one raw key; emits the
// debounced level and a one-cycle strobe on each accepted rising transition.
module m3_keyDebounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]      r_sync;
  logic [CntW-1:0] r_cnt;
  logic            r_level;
  logic            r_rise;
  logic            w_diff;
  logic            w_accept;

  assign w_diff   = r_sync[1] ^ r_level;
  // Accept on the DEB_CYCLES-th consecutive sample that differs from the held level.
  assign w_accept = w_diff && (r_cnt == CntW'(DEB_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_key};
      if (!w_diff || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_accept) begin
        r_level <= r_sync[1];
      end
      r_rise <= w_accept && r_sync[1];
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/m3_motorcmdsequencer.sv
// Operator-key front end for the 3-phase power/speed calculator: debounces keys and
// sequences start/stop/reverse with a brake-halt-dwell-invert-restart sequence.
module m3_motorcmdsequencer
  import m3_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DefDebCycles,
  parameter int unsigned BRAKE_CYCLES = DefBrakeCycles,
  parameter int unsigned DWELL_CYCLES = DefDwellCycles
) (
  input  logic       clkI,
  input  logic       nRstI,
  input  logic       keyStartI,
  input  logic       keyStopI,
  input  logic       keyDirI,
  input  logic       keySpdUpI,
  input  logic       keySpdDnI,
  input  logic       keyPwrUpI,
  input  logic       keyPwrDnI,
  output logic       m3startO,
  output logic       m3forceStopO,
  output logic       m3invRotateO,
  output logic       m3speedDECo,
  output logic       m3speedINCo,
  output logic       m3powerINCo,
  output logic       m3powerDECo,
  output logic [2:0] smO
);

  localparam int unsigned CntMax = max_u(BRAKE_CYCLES, DWELL_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic [NumKeys-1:0] w_keys;
  logic [NumKeys-1:0] w_level;
  logic [NumKeys-1:0] w_rise;
  logic               w_unused_keys;

  assign w_keys = {keyPwrDnI, keyPwrUpI, keySpdDnI, keySpdUpI, keyDirI, keyStopI, keyStartI};

  for (genvar g = 0; g < NumKeys; g++) begin : g_key
    m3_keyDebounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .i_clk  (clkI),
      .i_rst_n(nRstI),
      .i_key  (w_keys[g]),
      .o_level(w_level[g]),
      .o_rise (w_rise[g])
    );
  end

  // Command keys act only on edges, step keys only on levels.
  assign w_unused_keys = ^{w_level[KeyDir:KeyStart], w_rise[KeyPwrDn:KeySpdUp]};

  logic [2:0]      r_state;
  logic [2:0]      w_state_d;
  logic [CntW-1:0] r_cnt;
  logic            r_dir;

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_rise[KeyStart]) w_state_d = StRun;
      StRun:   if (w_rise[KeyDir]) w_state_d = StBrake;
      StBrake: if (r_cnt == '0) w_state_d = StHalt;
      StHalt:  w_state_d = StDwell;
      StDwell: if (r_cnt == '0) w_state_d = StRun;
      StFstop: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (w_rise[KeyStop] && (r_state != StIdle)) begin
      w_state_d = StFstop;
    end
  end

  // Counter is loaded on entry so each timed state lasts exactly its cycle count.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else begin
      if ((r_state != StBrake) && (w_state_d == StBrake)) begin
        r_cnt <= CntW'(BRAKE_CYCLES - 1);
      end else if ((r_state != StDwell) && (w_state_d == StDwell)) begin
        r_cnt <= CntW'(DWELL_CYCLES - 1);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CntW'(1);
      end
      if ((r_state == StDwell) && (w_state_d == StRun)) begin
        r_dir <= ~r_dir;
      end
    end
  end

  logic w_start_d;
  logic w_fstop_d;
  logic w_sdec_d;
  logic w_sinc_d;
  logic w_pinc_d;
  logic w_pdec_d;

  always_comb begin
    w_start_d = 1'b0;
    w_fstop_d = 1'b0;
    w_sdec_d  = 1'b0;
    w_sinc_d  = 1'b0;
    w_pinc_d  = 1'b0;
    w_pdec_d  = 1'b0;
    case (r_state)
      StRun: begin
        w_start_d = 1'b1;
        w_sdec_d  = w_level[KeySpdUp] & ~w_level[KeySpdDn];
        w_sinc_d  = w_level[KeySpdDn] & ~w_level[KeySpdUp];
        w_pinc_d  = w_level[KeyPwrUp] & ~w_level[KeyPwrDn];
        w_pdec_d  = w_level[KeyPwrDn] & ~w_level[KeyPwrUp];
      end
      StBrake: begin
        w_start_d = 1'b1;
        w_sinc_d  = 1'b1;
      end
      StFstop: w_fstop_d = 1'b1;
      default: ;
    endcase
  end

  logic r_start;
  logic r_fstop;
  logic r_sdec;
  logic r_sinc;
  logic r_pinc;
  logic r_pdec;

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      r_start <= 1'b0;
      r_fstop <= 1'b0;
      r_sdec  <= 1'b0;
      r_sinc  <= 1'b0;
      r_pinc  <= 1'b0;
      r_pdec  <= 1'b0;
    end else begin
      r_start <= w_start_d;
      r_fstop <= w_fstop_d;
      r_sdec  <= w_sdec_d;
      r_sinc  <= w_sinc_d;
      r_pinc  <= w_pinc_d;
      r_pdec  <= w_pdec_d;
    end
  end

  assign m3startO     = r_start;
  assign m3forceStopO = r_fstop;
  assign m3invRotateO = r_dir;
  assign m3speedDECo  = r_sdec;
  assign m3speedINCo  = r_sinc;
  assign m3powerINCo  = r_pinc;
  assign m3powerDECo  = r_pdec;
  assign smO          = r_state;

endmodule
